reaction_game_countdown: RTL and testbench

//  Loadable down-counter that consumes the 1 ms tick from the game's millisecond prescaler.

---
 rtl/reaction_game_pkg.sv | 12 +
 rtl/reaction_game_countdown.sv | 85 ++++++++
 tb/tb_reaction_game_countdown.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reaction_game_pkg.sv
// Shared types and defaults for the reaction-game countdown timer.
package reaction_game_pkg;

    typedef enum logic [1:0] {
        CD_IDLE    = 2'd0,
        CD_RUN     = 2'd1,
        CD_EXPIRED = 2'd2
    } cd_state_t;

    localparam int CD_WIDTH_DEFAULT = 14;

endpackage

// File: rtl/reaction_game_countdown.sv
// Loadable millisecond down-counter for the reaction game.
// Handles the random pre-LED wait and the "too slow" timeout.
// When the counter reaches zero it raises a one-cycle done pulse.
// It then holds the expired level until the next start, abort or reset.
// Optional feature macro: REACTION_GAME_COUNTDOWN_PAUSE_EN.
// When defined, it adds a pause input that freezes the count while running.
module reaction_game_countdown
    import reaction_game_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             abort,
`ifdef REACTION_GAME_COUNTDOWN_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    cd_state_t        state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             hold_c;

    // Pause only gates ticks; start/abort keep their priority regardless.
`ifdef REACTION_GAME_COUNTDOWN_PAUSE_EN
    assign hold_c = pause;
`else
    assign hold_c = 1'b0;
`endif

    // Next state / next count, priority abort > start > tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = CD_IDLE;
            rem_d   = '0;
        end else if (start) begin
            rem_d = load_val;
            if (load_val == '0) begin
                state_d = CD_EXPIRED;
                done_d  = 1'b1;
            end else begin
                state_d = CD_RUN;
            end
        end else if (state_q == CD_RUN && tick && !hold_c) begin
            // A count of 0 cannot occur in CD_RUN; treating it like 1 keeps the counter from wrapping.
            if (rem_q <= WIDTH'(1)) begin
                rem_d   = '0;
                state_d = CD_EXPIRED;
                done_d  = 1'b1;
            end else begin
                rem_d = rem_q - WIDTH'(1);
            end
        end
    end

    // State, count and done registers; reset wins over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CD_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign remaining = rem_q;
    assign busy      = (state_q == CD_RUN);
    assign expired   = (state_q == CD_EXPIRED);
    assign done      = done_q;

endmodule

// File: tb/tb_reaction_game_countdown.sv
// Directed scoreboard bench for reaction_game_countdown.
// The driver pushes hand-computed post-edge outputs for each vector.
// The monitor pops and compares one entry after every clock edge.
module tb_reaction_game_countdown;

    localparam int W = 14;

    typedef struct {
        logic [W-1:0] rem;
        logic         busy;
        logic         done;
        logic         expd;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         abort = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] remaining;
    logic         busy, done, expired;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reaction_game_countdown #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .load_val (load_val),
        .abort    (abort),
`ifdef REACTION_GAME_COUNTDOWN_PAUSE_EN
        .pause    (pause),
`endif
        .remaining(remaining),
        .busy     (busy),
        .done     (done),
        .expired  (expired)
    );

    // Drive one cycle of inputs and queue the expected outputs after the next edge.
    task automatic vec(input logic r, input logic st, input logic tk, input logic ab,
                       input logic pz, input int lv,
                       input int e_rem, input logic e_busy, input logic e_done,
                       input logic e_exp, input string nm);
        exp_t e;
        @(negedge clk);
        reset = r; start = st; tick = tk; abort = ab; pause = pz;
        load_val = W'(lv);
        e.rem = W'(e_rem); e.busy = e_busy; e.done = e_done; e.expd = e_exp; e.name = nm;
        sb_q.push_back(e);
    endtask

    // Idle cycles with no tick: outputs must hold.
    task automatic idle(input int n, input int e_rem, input logic e_busy,
                        input logic e_exp, input string nm);
        for (int i = 0; i < n; i++) vec(0, 0, 0, 0, 0, 0, e_rem, e_busy, 0, e_exp, nm);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_checks++;
                if (remaining !== e.rem || busy !== e.busy || done !== e.done || expired !== e.expd) begin
                    n_fail++;
                    $display("FAIL %s: got rem=%0d busy=%b done=%b exp=%b, want rem=%0d busy=%b done=%b exp=%b",
                             e.name, remaining, busy, done, expired, e.rem, e.busy, e.done, e.expd);
                end
            end
        end
    end

    initial begin
        // 1. reset dominates start and tick
        for (int i = 0; i < 3; i++) vec(1, 1, 1, 0, 0, 7, 0, 0, 0, 0, "reset");

        // 2. load 3, tick every 5th cycle
        vec(0, 1, 0, 0, 0, 3, 3, 1, 0, 0, "ld3_start");
        idle(4, 3, 1, 0, "ld3_hold3");
        vec(0, 0, 1, 0, 0, 0, 2, 1, 0, 0, "ld3_tick1");
        idle(4, 2, 1, 0, "ld3_hold2");
        vec(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, "ld3_tick2");
        idle(4, 1, 1, 0, "ld3_hold1");
        vec(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "ld3_done");
        vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "ld3_expired_tick");
        idle(2, 0, 0, 1, "ld3_expired_hold");

        // 3. load 0 expires immediately
        vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, "ld0_done");
        idle(2, 0, 0, 1, "ld0_expired");

        // 4. tick in start cycle ignored; abort beats tick
        vec(0, 1, 1, 0, 0, 5, 5, 1, 0, 0, "ld5_start_tick");
        vec(0, 0, 1, 0, 0, 0, 4, 1, 0, 0, "ld5_t4");
        vec(0, 0, 1, 0, 0, 0, 3, 1, 0, 0, "ld5_t3");
        vec(0, 0, 1, 0, 0, 0, 2, 1, 0, 0, "ld5_t2");
        vec(0, 1, 1, 1, 0, 9, 0, 0, 0, 0, "ld5_abort");
        vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "idle_tick");
        idle(2, 0, 0, 0, "idle_hold");

        // 5. restart while running and from expired
        vec(0, 1, 0, 0, 0, 4, 4, 1, 0, 0, "rs_ld4");
        vec(0, 1, 1, 0, 0, 10, 10, 1, 0, 0, "rs_ld10");
        vec(0, 0, 1, 0, 0, 0, 9, 1, 0, 0, "rs_t9");
        vec(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, "rs_ld1");
        vec(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "rs_done");
        vec(0, 1, 0, 0, 0, 2, 2, 1, 0, 0, "exp_ld2");
        vec(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, "exp_t1");
        vec(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "exp_done");
        vec(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "exp_abort");

        // full-width load, then synchronous reset mid-run
        vec(0, 1, 0, 0, 0, 16383, 16383, 1, 0, 0, "max_ld");
        vec(0, 0, 1, 0, 0, 0, 16382, 1, 0, 0, "max_t");
        vec(1, 1, 1, 0, 0, 6, 0, 0, 0, 0, "reset_run");

`ifdef REACTION_GAME_COUNTDOWN_PAUSE_EN
        // 6. pause freezes ticks only in CD_RUN
        vec(0, 1, 0, 0, 0, 4, 4, 1, 0, 0, "pz_ld4");
        for (int i = 0; i < 3; i++) vec(0, 0, 1, 0, 1, 0, 4, 1, 0, 0, "pz_hold");
        vec(0, 0, 1, 0, 0, 0, 3, 1, 0, 0, "pz_t3");
        vec(0, 0, 1, 0, 0, 0, 2, 1, 0, 0, "pz_t2");
        vec(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, "pz_t1");
        vec(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "pz_done");
        vec(0, 1, 0, 0, 1, 3, 3, 1, 0, 0, "pz_ld3_paused");
        vec(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, "pz_abort");
`endif
        idle(1, 0, 0, 0, "final_idle");

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
